// File: rtl/video_pkg.sv
// Shared definitions for the video image-load path: load FSM states and default image sizes.
package video_pkg;

    localparam logic [16:0] BG_WORDS_DEFAULT     = 17'd129600;
    localparam logic [16:0] SPRITE_BYTES_DEFAULT = 17'd32768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BG,
        ST_SP_HI,
        ST_SP_LO,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/image_load_controller.sv
// Streams the background (RGB565 words) or the spritesheet (alpha bytes, two per word)
// from a valid/ready source into image memory through a shared write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; starts the highest-priority pending load
// ST_BG    | accepting background words, one write per word
// ST_SP_HI | accepting a sprite word; high byte written next cycle
// ST_SP_LO | writing the held low byte; source stalled
// ST_DONE  | one-cycle completion pulse, loaded flag set
module image_load_controller
    import video_pkg::*;
#(
    parameter logic [16:0] BG_WORDS     = BG_WORDS_DEFAULT,
    parameter logic [16:0] SPRITE_BYTES = SPRITE_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bg_load_req,
    input  logic        sprite_load_req,
    input  logic        abort,
    input  logic        data_valid,
    input  logic [15:0] data_in,
    output logic        data_ready,
    output logic        background_write_en,
    output logic        spritesheet_write_en,
    output logic [16:0] image_write_addr,
    output logic [15:0] image_write_data,
    output logic        busy,
    output logic        bg_loaded,
    output logic        sprite_loaded,
    output logic        done
);

    load_state_t state;
    logic [16:0] cnt;
    logic        bg_pend;
    logic        sp_pend;
    logic [7:0]  lo_byte;
    logic        accept;
    logic        start_bg;
    logic        start_sp;

    assign accept   = data_valid && data_ready;
    assign start_bg = (state == ST_IDLE) && bg_pend && !abort;
    assign start_sp = (state == ST_IDLE) && !bg_pend && sp_pend && !abort;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            bg_pend              <= 1'b0;
            sp_pend              <= 1'b0;
            lo_byte              <= '0;
            data_ready           <= 1'b0;
            background_write_en  <= 1'b0;
            spritesheet_write_en <= 1'b0;
            image_write_addr     <= '0;
            image_write_data     <= '0;
            bg_loaded            <= 1'b0;
            sprite_loaded        <= 1'b0;
            done                 <= 1'b0;
        end else begin
            background_write_en  <= 1'b0;
            spritesheet_write_en <= 1'b0;
            done                 <= 1'b0;

            // A request for the kind already loading (or starting now) is absorbed.
            if (abort) begin
                bg_pend <= 1'b0;
                sp_pend <= 1'b0;
            end else begin
                if (start_bg)
                    bg_pend <= 1'b0;
                else if (bg_load_req && state != ST_BG)
                    bg_pend <= 1'b1;
                if (start_sp)
                    sp_pend <= 1'b0;
                else if (sprite_load_req && state != ST_SP_HI && state != ST_SP_LO)
                    sp_pend <= 1'b1;
            end

            if (abort) begin
                state      <= ST_IDLE;
                data_ready <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_bg) begin
                            state      <= ST_BG;
                            cnt        <= '0;
                            bg_loaded  <= 1'b0;
                            data_ready <= 1'b1;
                        end else if (start_sp) begin
                            state         <= ST_SP_HI;
                            cnt           <= '0;
                            sprite_loaded <= 1'b0;
                            data_ready    <= 1'b1;
                        end
                    end
                    ST_BG: begin
                        if (accept) begin
                            background_write_en <= 1'b1;
                            image_write_addr    <= cnt;
                            image_write_data    <= data_in;
                            cnt                 <= cnt + 17'd1;
                            if (cnt == BG_WORDS - 17'd1) begin
                                state      <= ST_DONE;
                                data_ready <= 1'b0;
                                done       <= 1'b1;
                                bg_loaded  <= 1'b1;
                            end
                        end
                    end
                    ST_SP_HI: begin
                        if (accept) begin
                            spritesheet_write_en <= 1'b1;
                            image_write_addr     <= cnt;
                            image_write_data     <= {8'h00, data_in[15:8]};
                            lo_byte              <= data_in[7:0];
                            cnt                  <= cnt + 17'd1;
                            state                <= ST_SP_LO;
                            data_ready           <= 1'b0;
                        end
                    end
                    ST_SP_LO: begin
                        spritesheet_write_en <= 1'b1;
                        image_write_addr     <= cnt;
                        image_write_data     <= {8'h00, lo_byte};
                        cnt                  <= cnt + 17'd1;
                        if (cnt == SPRITE_BYTES - 17'd1) begin
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            sprite_loaded <= 1'b1;
                        end else begin
                            state      <= ST_SP_HI;
                            data_ready <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_load_controller.sv
// Bench for image_load_controller with small image sizes: vector table, corner sequences,
// and random traffic against a write-queue reference model.
module tb_image_load_controller;

    localparam logic [16:0] NBG = 17'd4;
    localparam logic [16:0] NSP = 17'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bg_load_req, sprite_load_req, abort, data_valid;
    logic [15:0] data_in;
    logic        data_ready, background_write_en, spritesheet_write_en;
    logic [16:0] image_write_addr;
    logic [15:0] image_write_data;
    logic        busy, bg_loaded, sprite_loaded, done;

    image_load_controller #(.BG_WORDS(NBG), .SPRITE_BYTES(NSP)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .bg_load_req         (bg_load_req),
        .sprite_load_req     (sprite_load_req),
        .abort               (abort),
        .data_valid          (data_valid),
        .data_in             (data_in),
        .data_ready          (data_ready),
        .background_write_en (background_write_en),
        .spritesheet_write_en(spritesheet_write_en),
        .image_write_addr    (image_write_addr),
        .image_write_data    (image_write_data),
        .busy                (busy),
        .bg_loaded           (bg_loaded),
        .sprite_loaded       (sprite_loaded),
        .done                (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model: a job plus a queue of scheduled writes
    typedef struct {
        bit          sp;
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    int          job;          // 0 none, 1 background, 2 sprite
    int          sched;        // memory units scheduled in the current job
    bit          done_cycle;
    bit          pb, ps;
    bit          m_bgwe, m_spwe, m_done, m_bgl, m_spl;
    logic [16:0] m_addr;
    logic [15:0] m_data;

    function automatic int job_total(input int j);
        return (j == 1) ? int'(NBG) : int'(NSP);
    endfunction

    function automatic bit m_ready();
        return (job != 0) && (wq.size() == 0) && (sched < job_total(job));
    endfunction

    task automatic model_reset();
        wq.delete();
        job = 0; sched = 0; done_cycle = 0; pb = 0; ps = 0;
        m_bgwe = 0; m_spwe = 0; m_done = 0; m_bgl = 0; m_spl = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic model_edge(input bit bq, input bit sq, input bit ab, input bit dv,
                              input logic [15:0] d);
        bit  acc, idle_now, st_bg, st_sp;
        int  old_job;
        wr_t w;
        acc    = dv && m_ready();
        m_bgwe = 0; m_spwe = 0; m_done = 0;
        if (ab) begin
            job = 0; done_cycle = 0; pb = 0; ps = 0; wq.delete();
            return;
        end
        idle_now   = (job == 0) && !done_cycle;
        st_bg      = idle_now && pb;
        st_sp      = idle_now && !pb && ps;
        old_job    = job;
        done_cycle = 0;
        if (st_bg) pb = 0; else if (bq && old_job != 1) pb = 1;
        if (st_sp) ps = 0; else if (sq && old_job != 2) ps = 1;
        if (old_job != 0 && acc) begin
            if (old_job == 1) begin
                wq.push_back('{1'b0, 17'(sched), d});
                sched++;
            end else begin
                wq.push_back('{1'b1, 17'(sched), {8'h00, d[15:8]}});
                wq.push_back('{1'b1, 17'(sched + 1), {8'h00, d[7:0]}});
                sched += 2;
            end
        end
        if (wq.size() > 0) begin
            w = wq.pop_front();
            if (w.sp) m_spwe = 1; else m_bgwe = 1;
            m_addr = w.addr;
            m_data = w.data;
        end
        if (old_job != 0 && sched == job_total(old_job) && wq.size() == 0) begin
            m_done = 1;
            if (old_job == 1) m_bgl = 1; else m_spl = 1;
            job = 0;
            done_cycle = 1;
        end
        if (st_bg) begin job = 1; sched = 0; m_bgl = 0; end
        if (st_sp) begin job = 2; sched = 0; m_spl = 0; end
    endtask

    function automatic logic [39:0] model_vec();
        return {m_ready(), m_bgwe, m_spwe, m_addr, m_data,
                (job != 0) || done_cycle, m_done, m_bgl, m_spl};
    endfunction

    // ---------------- helpers
    function automatic logic [39:0] mk(input logic rdy, input logic bgwe, input logic spwe,
                                       input logic [16:0] addr, input logic [15:0] data,
                                       input logic bsy, input logic dn,
                                       input logic bgl, input logic spl);
        return {rdy, bgwe, spwe, addr, data, bsy, dn, bgl, spl};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {data_ready, background_write_en, spritesheet_write_en, image_write_addr,
                image_write_data, busy, done, bg_loaded, sprite_loaded};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cycle(input bit bq, input bit sq, input bit ab, input bit dv,
                         input logic [15:0] d);
        bg_load_req = bq; sprite_load_req = sq; abort = ab; data_valid = dv; data_in = d;
        @(posedge clk);
        model_edge(bq, sq, ab, dv, d);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bg_load_req = 0; sprite_load_req = 0; abort = 0; data_valid = 0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 40'h0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          bq, sq, ab, dv;
        logic [15:0] d;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int          dones, bgw, spw, sp_before, nwr;
        bit          first_done_bg, bg_done_seen;

        // background of 4 words, then sprite of 4 bytes (words AB12, CD34)
        tbl[0]  = '{1, 0, 0, 0, 16'h0000, mk(0, 0, 0, 17'd0, 16'h0000, 0, 0, 0, 0)};
        tbl[1]  = '{0, 0, 0, 0, 16'h0000, mk(1, 0, 0, 17'd0, 16'h0000, 1, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, 1, 16'h1111, mk(1, 1, 0, 17'd0, 16'h1111, 1, 0, 0, 0)};
        tbl[3]  = '{0, 0, 0, 1, 16'h2222, mk(1, 1, 0, 17'd1, 16'h2222, 1, 0, 0, 0)};
        tbl[4]  = '{0, 0, 0, 1, 16'h3333, mk(1, 1, 0, 17'd2, 16'h3333, 1, 0, 0, 0)};
        tbl[5]  = '{0, 0, 0, 1, 16'h4444, mk(0, 1, 0, 17'd3, 16'h4444, 1, 1, 1, 0)};
        tbl[6]  = '{0, 0, 0, 0, 16'h0000, mk(0, 0, 0, 17'd3, 16'h4444, 0, 0, 1, 0)};
        tbl[7]  = '{0, 1, 0, 0, 16'h0000, mk(0, 0, 0, 17'd3, 16'h4444, 0, 0, 1, 0)};
        tbl[8]  = '{0, 0, 0, 0, 16'h0000, mk(1, 0, 0, 17'd3, 16'h4444, 1, 0, 1, 0)};
        tbl[9]  = '{0, 0, 0, 1, 16'hAB12, mk(0, 0, 1, 17'd0, 16'h00AB, 1, 0, 1, 0)};
        tbl[10] = '{0, 0, 0, 1, 16'hCD34, mk(1, 0, 1, 17'd1, 16'h0012, 1, 0, 1, 0)};
        tbl[11] = '{0, 0, 0, 1, 16'hCD34, mk(0, 0, 1, 17'd2, 16'h00CD, 1, 0, 1, 0)};
        tbl[12] = '{0, 0, 0, 0, 16'h0000, mk(0, 0, 1, 17'd3, 16'h0034, 1, 1, 1, 1)};
        tbl[13] = '{0, 0, 0, 0, 16'h0000, mk(0, 0, 0, 17'd3, 16'h0034, 0, 0, 1, 1)};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].bq, tbl[i].sq, tbl[i].ab, tbl[i].dv, tbl[i].d);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // both requests together: background first, sprite follows unrequested
        do_reset();
        cycle(1, 1, 0, 0, 16'h0);
        dones = 0; bgw = 0; spw = 0; sp_before = 0; first_done_bg = 0; bg_done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 1, 16'($urandom));
            if (background_write_en) bgw++;
            if (spritesheet_write_en) begin
                spw++;
                if (!bg_done_seen) sp_before++;
            end
            if (done) begin
                if (dones == 0) begin
                    first_done_bg = bg_loaded && !sprite_loaded;
                    bg_done_seen  = 1;
                end
                dones++;
            end
        end
        check_int("both_bg_writes", bgw, 4);
        check_int("both_sp_writes", spw, 4);
        check_int("both_sp_before_bg_done", sp_before, 0);
        check_int("both_first_done_is_bg", int'(first_done_bg), 1);
        check_int("both_done_pulses", dones, 2);
        check_int("both_sprite_loaded", int'(sprite_loaded), 1);

        // abort after two background words
        do_reset();
        cycle(1, 0, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 16'h0);
        cycle(0, 0, 0, 1, 16'h0A0A);
        cycle(0, 0, 0, 1, 16'h0B0B);
        cycle(0, 0, 1, 0, 16'h0);
        check("abort_idle", dut_vec(), mk(0, 0, 0, 17'd1, 16'h0B0B, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 16'h0C0C);
            check("abort_no_accept", dut_vec(), mk(0, 0, 0, 17'd1, 16'h0B0B, 0, 0, 0, 0));
        end

        // data_valid toggling during a background load
        do_reset();
        cycle(1, 0, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 16'h0);
        nwr = 0; dones = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, (i % 2) == 0, 16'(16'h0100 + i));
            if (background_write_en) begin
                check_int("toggle_addr", int'(image_write_addr), nwr);
                check_int("toggle_data", int'(image_write_data), 16'h0100 + i);
                check_int("toggle_on_valid", i % 2, 0);
                nwr++;
            end
            if (done) dones++;
        end
        check_int("toggle_writes", nwr, 4);
        check_int("toggle_done_pulses", dones, 1);
        check_int("toggle_bg_loaded", int'(bg_loaded), 1);

        // asynchronous reset in the middle of a sprite load
        do_reset();
        cycle(0, 1, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 16'h0);
        cycle(0, 0, 0, 1, 16'hBEEF);
        check("sp_mid_load", dut_vec(), mk(0, 0, 1, 17'd0, 16'h00BE, 1, 0, 0, 0));
        #2 reset_n = 1'b0;
        #1 check("async_reset", dut_vec(), 40'h0);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7, 16'($urandom));
            check($sformatf("random%0d", i), dut_vec(), model_vec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_load_controller.md
IMAGE_LOAD_CONTROLLER -- requirements
Module: image_load_controller

Interface
REQ-001 Parameter BG_WORDS, default 17'd129600, number of 16-bit RGB565 background words (360x360).
REQ-002 Parameter SPRITE_BYTES, default 17'd32768, number of 8-bit spritesheet alpha bytes; SHALL be even and at most 32768.
REQ-003 Port clk, in, 1, sole clock.
REQ-004 Port reset_n, in, 1, asynchronous active-low reset.
REQ-005 Port bg_load_req, in, 1, single-cycle request to load the background image.
REQ-006 Port sprite_load_req, in, 1, single-cycle request to load the spritesheet.
REQ-007 Port abort, in, 1, synchronous cancel of any load in progress.
REQ-008 Port data_valid, in, 1, source word present on data_in.
REQ-009 Port data_in, in, 16, source word; for sprite loads, high byte is the first pixel.
REQ-010 Port data_ready, out, 1, controller accepts data_in this cycle.
REQ-011 Port background_write_en, out, 1, background memory write strobe.
REQ-012 Port spritesheet_write_en, out, 1, spritesheet memory write strobe.
REQ-013 Port image_write_addr, out, 17, shared write address.
REQ-014 Port image_write_data, out, 16, shared write data; for sprite writes, byte in [7:0] and [15:8]=0.
REQ-015 Port busy, out, 1, high in any state other than IDLE.
REQ-016 Ports bg_loaded and sprite_loaded, out, 1 each, the corresponding image is completely loaded.
REQ-017 Port done, out, 1, one-cycle pulse when a load completes.

Function
REQ-018 States: IDLE, BG, SP_HI, SP_LO, DONE.
REQ-019 Requests latch into pending flags bg_pend and sp_pend.
REQ-020 A request for the kind currently loading is ignored.
REQ-021 In IDLE with any pending flag set, the controller starts a load, clears that flag, zeroes the address counter and clears the matching loaded flag.
REQ-022 Priority is fixed: background wins when both flags are set.
REQ-023 A word is accepted when data_valid && data_ready.
REQ-024 data_ready is high only in BG and SP_HI.
REQ-025 In BG, a word accepted in cycle N yields background_write_en=1, addr=counter, data=word in cycle N+1; the counter then increments.
REQ-026 In SP_HI, a word accepted in cycle N yields a high-byte write at addr a in N+1, in state SP_LO with data_ready=0, and a low-byte write at a+1 in N+2.
REQ-027 SP_LO returns to SP_HI, or to DONE after the final byte.
REQ-028 Both write strobes are registered and are never high together; each is high for exactly one cycle per write.
REQ-029 After the write at addr BG_WORDS-1 (background) or SPRITE_BYTES-1 (sprite), the next state is DONE.
REQ-030 DONE lasts one cycle: done=1, matching loaded flag set, next state IDLE.
REQ-031 Pending requests are serviced from IDLE after DONE.
REQ-032 abort in any state: next state IDLE, no done pulse, both pending flags cleared, the active kind's loaded flag stays 0, any in-flight strobe completes.
REQ-033 abort has priority over a simultaneous request in the same cycle.
REQ-034 The counter is 17 bits and never wraps; the terminal compare ends the load.
REQ-035 A sprite address never exceeds 15 significant bits.

Reset
REQ-036 Reset_n low forces: state IDLE, counter 0, pending flags 0, data_ready 0, both write strobes 0, image_write_addr 0, image_write_data 0, busy 0, bg_loaded 0, sprite_loaded 0, done 0.
REQ-037 Reset mid-load discards the partial load; the memory contents are left untouched.

Structure
REQ-038 The state enum and the BG_WORDS/SPRITE_BYTES defaults belong in shared package video_pkg.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 BG_WORDS=4, bg_load_req pulse, 4 words with valid held -> 4 background writes at addr 0..3 on consecutive cycles, done pulse once, bg_loaded=1.
REQ-041 SPRITE_BYTES=4, words 16'hAB12, 16'hCD34 -> sprite writes (0,0x00AB),(1,0x0012),(2,0x00CD),(3,0x0034); data_ready low on each SP_LO cycle.
REQ-042 bg_load_req and sprite_load_req in the same cycle -> background load completes first, then the sprite load starts without a new request.
REQ-043 abort after 2 of 4 background words -> IDLE next cycle, no done, bg_loaded=0, subsequent words not accepted.
REQ-044 data_valid toggled 1,0,1,0 during a BG load -> writes only on accepted words, addresses contiguous.
REQ-045 reset_n asserted mid sprite load -> all outputs at REQ-036 values immediately, without waiting for a clock edge.
